// File: rtl/led_mode_controller_pkg.sv
// led_mode_controller shared definitions.
// Mode encoding, press FSM states, mode stepping.
package led_pkg;

   localparam logic [1:0] MODE_OFF  = 2'd0;
   localparam logic [1:0] MODE_SLOW = 2'd1;
   localparam logic [1:0] MODE_FAST = 2'd2;
   localparam logic [1:0] MODE_ON   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESSED   = 2'd1,
      ST_LONG_HELD = 2'd2
   } press_state_e;

   function automatic logic [1:0] next_mode(input logic [1:0] m);
      return m + 2'd1;
   endfunction

endpackage

// File: rtl/led_mode_controller_if.sv
// Mode status bundle of the LED controller.
// master drives it, slave observes it.
interface led_mode_if;

   logic [1:0] mode;
   logic       mode_change;

   modport master (
      output mode,
      output mode_change
   );

   modport slave (
      input mode,
      input mode_change
   );

endinterface

// File: rtl/led_mode_controller_button_debounce.sv
// Two-flop synchroniser plus debounce counter.
// rise/fall pulse together with the level update.
module button_debounce
   import led_pkg::*;
#(
   parameter int unsigned CYCLES = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic raw_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = $clog2(CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          synced;

   assign synced = sync_q[1];

   // accept the synced level after CYCLES consecutive differing cycles
   always_comb begin
      sync_d  = {sync_q[0], raw_in};
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (synced == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = synced;
         rise_d  = synced;
         fall_d  = !synced;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // synchroniser, counter and debounced level registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/led_mode_controller.sv
// Button-driven LED mode controller.
// Short press steps the mode, long press forces OFF.
module led_mode_controller
   import led_pkg::*;
#(
   parameter int unsigned CLK_HZ            = 16000000,
   parameter int unsigned DEBOUNCE_CYCLES   = CLK_HZ / 100,
   parameter int unsigned LONG_PRESS_CYCLES = CLK_HZ,
   parameter int unsigned SLOW_HALF_CYCLES  = CLK_HZ / 2,
   parameter int unsigned FAST_HALF_CYCLES  = CLK_HZ / 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       PIN_14,
   output logic       LED,
   output logic       USBPU,
   led_mode_if.master status
);

   localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES) + 1;
   localparam int unsigned PH_MAX =
      (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ?
      SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
   localparam int unsigned PW = $clog2(PH_MAX) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_HALF_CYCLES - 1);
   localparam logic [PW-1:0] FAST_LAST = PW'(FAST_HALF_CYCLES - 1);

   logic btn_level, btn_rise, btn_fall;

   press_state_e  state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    mode_q, mode_d;
   logic          mode_change_q, mode_change_d;
   logic [PW-1:0] ph_cnt_q, ph_cnt_d;
   logic [PW-1:0] ph_last;
   logic          phase_q, phase_d;
   logic          blinking;

   button_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .raw_in (PIN_14),
      .level  (btn_level),
      .rise   (btn_rise),
      .fall   (btn_fall)
   );

   // press classification; threshold beats a same-cycle release
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      mode_d        = mode_q;
      mode_change_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (btn_rise) begin
               state_d = ST_PRESSED;
               hold_d  = '0;
            end
         end
         ST_PRESSED: begin
            hold_d = hold_q + 1'b1;
            if (hold_d == HOLD_LAST) begin
               mode_d        = MODE_OFF;
               mode_change_d = 1'b1;
               state_d       = ST_LONG_HELD;
            end else if (btn_fall) begin
               mode_d        = next_mode(mode_q);
               mode_change_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_LONG_HELD: begin
            if (!btn_level) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign blinking = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
   assign ph_last  = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

   // blink timebase, restarted lit on every mode update
   always_comb begin
      ph_cnt_d = ph_cnt_q;
      phase_d  = phase_q;
      if (mode_change_d || !blinking) begin
         ph_cnt_d = '0;
         phase_d  = 1'b1;
      end else if (ph_cnt_q == ph_last) begin
         ph_cnt_d = '0;
         phase_d  = !phase_q;
      end else begin
         ph_cnt_d = ph_cnt_q + 1'b1;
      end
   end

   // FSM, mode and blink registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_IDLE;
         hold_q        <= '0;
         mode_q        <= MODE_OFF;
         mode_change_q <= 1'b0;
         ph_cnt_q      <= '0;
         phase_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         mode_q        <= mode_d;
         mode_change_q <= mode_change_d;
         ph_cnt_q      <= ph_cnt_d;
         phase_q       <= phase_d;
      end
   end

   assign LED = (mode_q == MODE_ON) || (blinking && phase_q);
   assign USBPU = 1'b0;
   assign status.mode = mode_q;
   assign status.mode_change = mode_change_q;

endmodule

// File: doc/led_mode_controller.md
# led_mode_controller

Button-driven controller for the board's single user LED. Synchronises and debounces the push button on PIN_14, runs a press-classification state machine, and steps the LED through four display modes. It owns the blink timebase and drives LED directly. It replaces the fixed free-running blinker as the top-level LED source on the TinyFPGA BX (16 MHz CLK).

## Interface
- CLK_HZ, 16000000: clock frequency; informational only, used for default derivation.
- DEBOUNCE_CYCLES, 160000: consecutive stable cycles required to accept a button level (10 ms).
- LONG_PRESS_CYCLES, 16000000: hold duration that counts as a long press (1 s).
- SLOW_HALF_CYCLES, 8000000: half-period of SLOW blink (0.5 s).
- FAST_HALF_CYCLES, 2000000: half-period of FAST blink (0.125 s).
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- PIN_14  input  1  raw push button, asynchronous, 1 = pressed.
- LED  output  1  user LED, 1 = lit.
- USBPU  output  1  USB pull-up; constant 0.
- mode  output  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON.
- mode_change  output  1  one-cycle pulse on every mode register update.

## Operation
- Synchroniser: PIN_14 passes through 2 flops. Only the synchronised level is used.
- Debounce: counter clears whenever the synced level equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
- Press FSM states:
  - IDLE: debounced rise -> PRESSED, hold counter cleared.
  - PRESSED: hold counter increments each cycle.
    - Debounced fall before the count reaches LONG_PRESS_CYCLES-1 -> short press: mode advances 0->1->2->3->0 (2-bit wrap); go to IDLE.
    - Count reaches LONG_PRESS_CYCLES-1 while still held -> mode forced to OFF; go to LONG_HELD.
  - LONG_HELD: no mode action; debounced fall -> IDLE.
- mode_change pulses on short-press advance. It also pulses on long-press force-OFF, even when mode was already OFF.
- Blink timebase: phase counter counts 0..HALF-1, where HALF = SLOW_HALF_CYCLES or FAST_HALF_CYCLES. At HALF-1 it wraps to 0 and toggles phase.
  - On any mode update, the phase counter is cleared and phase is set to 1, so the LED lights immediately.
  - In OFF and ON, the phase counter is held at 0 and phase is held at 1.
- LED: OFF -> 0; ON -> 1; SLOW/FAST -> phase. LED is combinational from the mode and phase registers.
- USBPU tied to 0.

## Timing
- Reset values: LED 0, mode 0 (OFF), mode_change 0, USBPU 0, FSM in IDLE, all counters 0, debounced level 0, phase 1.
- Latency, PIN_14 edge to debounced edge: 2 sync cycles + DEBOUNCE_CYCLES cycles (stable input).
- Latency, debounced fall (short press) to mode/LED update: 1 cycle. mode_change asserts in that same cycle.
- Long press: mode goes to 0 exactly LONG_PRESS_CYCLES cycles after the debounced rise.
- Glitches shorter than DEBOUNCE_CYCLES are ignored completely.
- Wrap: mode 3 + short press -> 0.
- Reset mid-press: FSM returns to IDLE and mode to 0. A button still held after reset release produces a fresh debounced rise; its release counts as a short press.
- A debounced fall and the long-press threshold in the same cycle resolve as a long press.

## Structure
- Package led_pkg: 2-bit mode constants MODE_OFF/SLOW/FAST/ON and the FSM state encoding.
- Sub-module button_debounce: synchroniser plus debounce counter. Ports CLK, RST_N, raw in, debounced level out, rise/fall pulses out.
- Counter widths are $clog2 of the respective max + 1. No width is hardcoded.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, SLOW_HALF_CYCLES=8, FAST_HALF_CYCLES=3.
- Reset, button idle 50 cycles -> mode=0, LED=0, mode_change never asserts.
- Press 10 cycles, release -> mode=1 one cycle after the debounced fall, single mode_change pulse. LED=1 for 8 cycles, 0 for 8, repeating.
- Four short presses -> mode sequence 1,2,3,0, four mode_change pulses. LED in mode 2 toggles every 3 cycles; constant 1 in mode 3.
- In mode 2, hold 40 cycles -> mode=0 exactly 20 cycles after the debounced rise. Release causes no further change.
- 3-cycle pulses on PIN_14 and bounce (1/0 alternating for 10 cycles, then a stable press) -> only one debounced rise. Exactly one mode advance after release.
- Assert RST_N=0 mid-press in mode 3 -> LED=0 and mode=0 asynchronously. After release of RST_N with the button still held, a release gives mode=1.
